// File: rtl/i2c_cmd_sched.sv
// i2c_cmd_sched: queues 3-byte command blocks from the UART receiver, issues them
// one at a time to the I2C master, supervises each transfer with a timeout and
// returns a 2-byte status/data response to the UART transmitter.
// Device address 0 is a local status query answered without touching the bus.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   bl_valid/bl_com/bl_reg/bl_dat   incoming block strobe and its three bytes
//   i2c_start/dev/rw/reg/wdat       transfer request to the I2C master
//   i2c_busy/done/nack/rdat         master status and read result
//   rsp_valid/rsp_dat/rsp_ready     response byte stream (valid/ready)
//   q_full                          queue holds FIFO_DEPTH entries
//   drop_cnt                        saturating count of blocks dropped on full queue
module i2c_cmd_sched #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TIMEOUT    = 1024
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       bl_valid,
   input  logic [7:0] bl_com,
   input  logic [7:0] bl_reg,
   input  logic [7:0] bl_dat,
   output logic       i2c_start,
   output logic [6:0] i2c_dev,
   output logic       i2c_rw,
   output logic [7:0] i2c_reg,
   output logic [7:0] i2c_wdat,
   input  logic       i2c_busy,
   input  logic       i2c_done,
   input  logic       i2c_nack,
   input  logic [7:0] i2c_rdat,
   output logic       rsp_valid,
   output logic [7:0] rsp_dat,
   input  logic       rsp_ready,
   output logic       q_full,
   output logic [7:0] drop_cnt
);

   localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W   = PTR_W + 1;
   localparam int unsigned TMO_W   = $clog2(TIMEOUT);
   localparam int unsigned ENTRY_W = 24;

   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
   localparam logic [3:0]       ST_TAG   = 4'hA;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RSP_ST,
      ST_RSP_DAT
   } state_e;

   state_e               state_q, state_d;

   logic [ENTRY_W-1:0]   mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 q_full_q, q_full_d;
   logic [7:0]           drop_q, drop_d;

   logic                 start_q, start_d;
   logic [6:0]           dev_q, dev_d;
   logic                 rw_q, rw_d;
   logic [7:0]           reg_q, reg_d;
   logic [7:0]           wdat_q, wdat_d;

   logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
   logic                 local_q, local_d;
   logic [7:0]           data_q, data_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic [7:0]           rsp_dat_q, rsp_dat_d;

   logic                 push_c;
   logic                 drop_c;
   logic                 pop_c;
   logic                 drop_clr_c;
   logic [ENTRY_W-1:0]   head_c;

   // Queue storage; contents need no reset because pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push_c) begin
         mem_q[wr_ptr_q] <= {bl_com, bl_reg, bl_dat};
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         q_full_q    <= 1'b0;
         drop_q      <= 8'h00;
         start_q     <= 1'b0;
         dev_q       <= 7'h00;
         rw_q        <= 1'b0;
         reg_q       <= 8'h00;
         wdat_q      <= 8'h00;
         tmo_cnt_q   <= '0;
         local_q     <= 1'b0;
         data_q      <= 8'h00;
         rsp_valid_q <= 1'b0;
         rsp_dat_q   <= 8'h00;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         q_full_q    <= q_full_d;
         drop_q      <= drop_d;
         start_q     <= start_d;
         dev_q       <= dev_d;
         rw_q        <= rw_d;
         reg_q       <= reg_d;
         wdat_q      <= wdat_d;
         tmo_cnt_q   <= tmo_cnt_d;
         local_q     <= local_d;
         data_q      <= data_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_dat_q   <= rsp_dat_d;
      end
   end

   // Queue bookkeeping, drop counter and command FSM next-state logic.
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      q_full_d    = q_full_q;
      drop_d      = drop_q;
      start_d     = 1'b0;
      dev_d       = dev_q;
      rw_d        = rw_q;
      reg_d       = reg_q;
      wdat_d      = wdat_q;
      tmo_cnt_d   = tmo_cnt_q;
      local_d     = local_q;
      data_d      = data_q;
      rsp_valid_d = rsp_valid_q;
      rsp_dat_d   = rsp_dat_q;

      head_c = mem_q[rd_ptr_q];

      // Admission uses the registered count, so a same-cycle pop never frees a slot.
      push_c     = bl_valid && (count_q < DEPTH_C);
      drop_c     = bl_valid && !push_c;
      pop_c      = (state_q == ST_IDLE) && (count_q != '0) && !i2c_busy;
      drop_clr_c = (state_q == ST_RSP_DAT) && local_q && rsp_ready;

      if (push_c) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d  = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
      q_full_d = (count_d == DEPTH_C);

      // Reporting the drop count clears it; a drop in that very cycle is kept as 1.
      if (drop_clr_c) begin
         drop_d = drop_c ? 8'h01 : 8'h00;
      end else if (drop_c && (drop_q != 8'hFF)) begin
         drop_d = drop_q + 8'h01;
      end

      case (state_q)
         ST_IDLE: begin
            if (pop_c) begin
               dev_d  = head_c[23:17];
               rw_d   = head_c[16];
               reg_d  = head_c[15:8];
               wdat_d = head_c[7:0];
               if (head_c[23:17] == 7'h00) begin
                  // Local query: answer with the drop count seen on entry to RSP_ST.
                  local_d     = 1'b1;
                  data_d      = drop_d;
                  rsp_valid_d = 1'b1;
                  rsp_dat_d   = {ST_TAG, 1'b0, 1'b1, 1'b0, 1'b0};
                  state_d     = ST_RSP_ST;
               end else begin
                  local_d = 1'b0;
                  start_d = 1'b1;
                  state_d = ST_ISSUE;
               end
            end
         end

         ST_ISSUE: begin
            tmo_cnt_d = '0;
            state_d   = ST_WAIT;
         end

         ST_WAIT: begin
            // Completion takes priority over a timeout in the same cycle.
            if (i2c_done) begin
               data_d      = i2c_nack ? 8'h00 : (rw_q ? i2c_rdat : wdat_q);
               rsp_valid_d = 1'b1;
               rsp_dat_d   = {ST_TAG, 1'b0, local_q, 1'b0, i2c_nack};
               state_d     = ST_RSP_ST;
            end else if (tmo_cnt_q == TMO_LAST) begin
               data_d      = 8'h00;
               rsp_valid_d = 1'b1;
               rsp_dat_d   = {ST_TAG, 1'b0, local_q, 1'b1, 1'b0};
               state_d     = ST_RSP_ST;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
         end

         ST_RSP_ST: begin
            if (rsp_ready) begin
               rsp_dat_d = data_q;
               state_d   = ST_RSP_DAT;
            end
         end

         ST_RSP_DAT: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               rsp_dat_d   = 8'h00;
               state_d     = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign i2c_start = start_q;
   assign i2c_dev   = dev_q;
   assign i2c_rw    = rw_q;
   assign i2c_reg   = reg_q;
   assign i2c_wdat  = wdat_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_dat   = rsp_dat_q;
   assign q_full    = q_full_q;
   assign drop_cnt  = drop_q;

endmodule

// File: doc/i2c_cmd_sched.md
# i2c_cmd_sched

Command scheduler between the UART block receiver and the I2C master engine. It queues each received 3-byte block (command/device address, register address, data) and issues them one at a time to the I2C master. It supervises each transfer with a timeout and returns a 2-byte status/data response to the UART transmitter. Address 0 is a local status query and does not reach the bus.

## Interface
- FIFO_DEPTH, 4: queue entries (power of 2, ≥2); entry = {com[7:0], reg[7:0], dat[7:0]}
- TIMEOUT, 1024: clocks allowed in WAIT before a transfer is abandoned (≥2)
- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- bl_valid  in  1  one-cycle strobe: block complete (receiver ok_rx_bl)
- bl_com  in  8  command byte: [7:1] 7-bit device address, [0] R/W (1 = read)
- bl_reg  in  8  register address
- bl_dat  in  8  write data (ignored for reads)
- i2c_start  out  1  one-cycle pulse: begin transfer
- i2c_dev  out  7  device address, stable from i2c_start until i2c_done
- i2c_rw  out  1  1 = read, same stability
- i2c_reg  out  8  register address, same stability
- i2c_wdat  out  8  write data, same stability
- i2c_busy  in  1  master engaged; no issue while high
- i2c_done  in  1  one-cycle strobe: transfer finished
- i2c_nack  in  1  NACK seen; valid with i2c_done
- i2c_rdat  in  8  read byte; valid with i2c_done
- rsp_valid  out  1  response byte available
- rsp_dat  out  8  response byte
- rsp_ready  in  1  transmitter accepts; transfer on rsp_valid & rsp_ready
- q_full  out  1  queue holds FIFO_DEPTH entries
- drop_cnt  out  8  blocks dropped on full queue, saturates at 255

## Operation
- Reset: all outputs 0, queue empty, drop_cnt 0, state IDLE, timeout counter 0. Reset mid-transfer flushes the queue and discards the current command; no response is produced.
- Push: bl_valid with count < FIFO_DEPTH writes the entry. q_full and count are registered. A pop in the same cycle does not free a slot for that cycle's push. If the queue is full, the block is discarded and drop_cnt increments, saturating at 255.
- FSM states: IDLE, ISSUE, WAIT, RSP_ST, RSP_DAT.
- IDLE: when the queue is non-empty and i2c_busy=0, pop the head and latch its fields into the i2c_* outputs. If bl_com[7:1]==0, go to RSP_ST (local). Otherwise go to ISSUE.
- ISSUE: assert i2c_start for exactly one cycle, clear the timeout counter, go to WAIT.
- WAIT: on i2c_done, capture i2c_nack and i2c_rdat, then go to RSP_ST. If the counter reaches TIMEOUT-1 without i2c_done, set the timeout flag and go to RSP_ST. If i2c_done and timeout occur in the same cycle, i2c_done wins.
- i2c_done outside WAIT is ignored.
- Status byte: {4'hA, 1'b0, local, timeout, nack}.
- Data byte:
  - read success: captured rdat
  - write success: latched dat (echo)
  - nack or timeout: 8'h00
  - local: drop_cnt value at the moment RSP_ST is entered
- drop_cnt clears when the local data byte transfers. A drop in that same cycle sets drop_cnt to 1.
- RSP_ST: rsp_valid=1 with the status byte; on rsp_ready go to RSP_DAT.
- RSP_DAT: rsp_valid=1 with the data byte; on rsp_ready go to IDLE.
- Queue pushes continue in every state.

## Timing
- bl_valid in cycle 0 with the queue empty and the FSM in IDLE: entry stored at the end of cycle 0, popped in cycle 1, i2c_start high in cycle 2.
- Local command: status rsp_valid high in cycle 2.
- i2c_* fields change only on a pop in IDLE.
- rsp_valid, once asserted, stays high and rsp_dat stays stable until rsp_ready is sampled high. rsp_valid drops in the cycle after the data byte transfers.
- Back-to-back: after the data byte transfers (cycle n), IDLE in n+1 may pop, and the next i2c_start is at n+2.
- Timeout: with no i2c_done, RSP_ST is entered TIMEOUT cycles after the cycle following i2c_start.
- i2c_busy high in IDLE stalls the pop. The queue is unaffected.

## Test plan
- Write: block {0xA0,0x10,0x5A}, master returns done, nack=0, 5 cycles after start → i2c_dev=0x50, rw=0, reg=0x10, wdat=0x5A; i2c_start in cycle 2; response 0xA0, 0x5A.
- Read: {0xA1,0x22,xx}, done with rdat=0x3C → response 0xA0, 0x3C. Read with nack=1 → response 0xA1, 0x00.
- Timeout: TIMEOUT=16, never assert done → response 0xA2, 0x00 exactly 16 cycles after WAIT entry. A done pulse arriving later is ignored. The next queued command then issues normally.
- Overflow: i2c_busy held high, 6 blocks pushed → 4 queued, q_full=1, drop_cnt=2. A local query {0x00,..} issued after draining returns 0xA4, 0x02, and drop_cnt then reads 0.
- Backpressure: hold rsp_ready low for 10 cycles in RSP_ST → rsp_valid and rsp_dat=status stay stable, and no new i2c_start occurs. Pushes during the stall are accepted.
- Reset: assert rst_n low during WAIT with 2 entries queued → all outputs 0 immediately, queue empty. After release, no response and no i2c_start without new blocks.
